// File: rtl/uart_rx_framer.sv
// uart_rx_framer: turns the UART receiver's unframed byte stream into
// AXI-Stream packets. A packet closes on a delimiter byte, on MAX_LEN bytes,
// or after a programmable idle timeout. One byte is held back so the final
// byte can carry tlast without an empty beat.
module uart_rx_framer #(
    parameter int WORD_SIZE = 8,
    parameter int MAX_LEN   = 256
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [WORD_SIZE-1:0] s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [WORD_SIZE-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic [23:0]          timeout_config,
    input  logic                 delim_en,
    input  logic [WORD_SIZE-1:0] delim,
    output logic                 timeout_flush
);

    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [WORD_SIZE-1:0]  hold_data_q, hold_data_d;
    logic                  hold_err_q, hold_err_d;
    logic                  hold_last_q, hold_last_d;
    logic [WORD_SIZE-1:0]  out_data_q, out_data_d;
    logic [1:0]            out_user_q, out_user_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  err_acc_q, err_acc_d;
    logic [23:0]           idle_cnt_q, idle_cnt_d;
    logic [23:0]           tmo_q, tmo_d;
    logic                  delim_en_q, delim_en_d;
    logic [WORD_SIZE-1:0]  delim_q, delim_d;
    logic                  tflush_q, tflush_d;

    logic                  hold_v, out_free, s_rdy, accept;
    logic                  cfg_den, dmatch, tmo_thr, flush;
    logic [WORD_SIZE-1:0]  cfg_dlm;

    // Handshake, delimiter match and flush qualifiers
    always_comb begin
        hold_v   = (state_q == S_HOLD);
        out_free = ~out_valid_q | m_axis_tready;
        // A terminal byte in hold blocks intake until it is flushed; reset
        // also masks ready so upstream never sees it high while held.
        s_rdy    = aresetn & out_free & ~(hold_v & hold_last_q);
        accept   = s_axis_tvalid & s_rdy;
        // Config is still transparent in S_IDLE, so the first byte of a
        // packet is matched against the live delimiter being latched.
        cfg_den  = hold_v ? delim_en_q : delim_en;
        cfg_dlm  = hold_v ? delim_q    : delim;
        dmatch   = cfg_den & (s_axis_tdata == cfg_dlm);
        tmo_thr  = hold_v & ~hold_last_q & (tmo_q != 24'd0) &
                   (idle_cnt_q == tmo_q - 24'd1);
        // An accept on the threshold cycle takes priority over the timeout.
        flush    = hold_v & out_free & (hold_last_q | (tmo_thr & ~accept));
    end

    // Next-state, hold/output datapath and counters
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_err_d  = hold_err_q;
        hold_last_d = hold_last_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~m_axis_tready;
        len_d       = len_q;
        err_acc_d   = err_acc_q;
        idle_cnt_d  = idle_cnt_q;
        tmo_d       = tmo_q;
        delim_en_d  = delim_en_q;
        delim_d     = delim_q;
        tflush_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d      = timeout_config;
                delim_en_d = delim_en;
                delim_d    = delim;
                if (accept) begin
                    hold_data_d = s_axis_tdata;
                    hold_err_d  = s_axis_tuser;
                    hold_last_d = dmatch | (MAX_LEN == 1);
                    len_d       = LW'(1);
                    idle_cnt_d  = 24'd0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    out_data_d  = hold_data_q;
                    out_user_d  = {1'b0, hold_err_q};
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    err_acc_d   = err_acc_q | hold_err_q;
                    hold_data_d = s_axis_tdata;
                    hold_err_d  = s_axis_tuser;
                    hold_last_d = dmatch | (len_q + LW'(1) == LW'(MAX_LEN));
                    len_d       = len_q + LW'(1);
                    idle_cnt_d  = 24'd0;
                end else if (flush) begin
                    out_data_d  = hold_data_q;
                    out_user_d  = {err_acc_q | hold_err_q, hold_err_q};
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    len_d       = '0;
                    err_acc_d   = 1'b0;
                    idle_cnt_d  = 24'd0;
                    tflush_d    = ~hold_last_q;
                    state_d     = S_IDLE;
                end else if (idle_cnt_q != tmo_q - 24'd1) begin
                    idle_cnt_d  = idle_cnt_q + 24'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
            hold_last_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= 2'b00;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            len_q       <= '0;
            err_acc_q   <= 1'b0;
            idle_cnt_q  <= 24'd0;
            tmo_q       <= 24'd0;
            delim_en_q  <= 1'b0;
            delim_q     <= '0;
            tflush_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_err_q  <= hold_err_d;
            hold_last_q <= hold_last_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            len_q       <= len_d;
            err_acc_q   <= err_acc_d;
            idle_cnt_q  <= idle_cnt_d;
            tmo_q       <= tmo_d;
            delim_en_q  <= delim_en_d;
            delim_q     <= delim_d;
            tflush_q    <= tflush_d;
        end
    end

    assign s_axis_tready = s_rdy;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_valid_q;
    assign timeout_flush = tflush_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer (MAX_LEN=4): vector table for delimiter
// and max-length framing, hand sequences for timeout, backpressure, error
// accumulation, accept/timeout race and reset.
module tb_uart_rx_framer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [23:0] timeout_config;
    logic        delim_en;
    logic [7:0]  delim;
    logic        timeout_flush;

    int nchk = 0;
    int nerr = 0;

    uart_rx_framer #(.WORD_SIZE(8), .MAX_LEN(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .timeout_config(timeout_config), .delim_en(delim_en), .delim(delim),
        .timeout_flush(timeout_flush)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       su;
        logic       mr;
        logic       e_srdy;
        logic       e_mv;
        logic       e_ml;
        logic [1:0] e_mu;
        logic [7:0] e_md;
        logic       e_tf;
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic su,
                                input logic mr, input logic e_srdy, input logic e_mv,
                                input logic e_ml, input logic [1:0] e_mu,
                                input logic [7:0] e_md, input logic e_tf);
        vec_t v;
        v.sv = sv; v.sd = sd; v.su = su; v.mr = mr; v.e_srdy = e_srdy;
        v.e_mv = e_mv; v.e_ml = e_ml; v.e_mu = e_mu; v.e_md = e_md; v.e_tf = e_tf;
        return v;
    endfunction

    function automatic logic [31:0] pk(input logic mv, input logic ml, input logic [1:0] mu,
                                       input logic [7:0] md, input logic tf);
        return {19'b0, mv, ml, mu, md, tf};
    endfunction

    // Output fields only matter while tvalid is high
    function automatic logic [31:0] outs();
        if (m_axis_tvalid === 1'b1)
            return {19'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, timeout_flush};
        return {19'b0, m_axis_tvalid, 1'b0, 2'b00, 8'h00, timeout_flush};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic sv, input logic [7:0] sd, input logic su, input logic mr);
        @(negedge aclk);
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        s_axis_tuser  = su;
        m_axis_tready = mr;
    endtask

    task automatic tk();
        @(posedge aclk);
        #1;
    endtask

    task automatic cyc(input logic sv, input logic [7:0] sd, input logic su, input logic mr);
        drv(sv, sd, su, mr);
        tk();
    endtask

    task automatic do_reset(input string nm);
        @(negedge aclk);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; s_axis_tuser = 1'b1; m_axis_tready = 1'b1;
        #1;
        chk({nm, " srdy in reset"}, 32'(s_axis_tready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tk();
            chk($sformatf("%s outs in reset %0d", nm, i),
                {19'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, timeout_flush}, 32'd0);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk({nm, " srdy after release"}, 32'(s_axis_tready), 32'd1);
        tk();
        chk({nm, " outs after release"}, outs(), pk(0, 0, 2'b00, 8'h00, 0));
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vt[idx];
        drv(v.sv, v.sd, v.su, v.mr);
        #1;
        chk($sformatf("vec%0d srdy", idx), 32'(s_axis_tready), 32'(v.e_srdy));
        tk();
        chk($sformatf("vec%0d out", idx), outs(), pk(v.e_mv, v.e_ml, v.e_mu, v.e_md, v.e_tf));
    endtask

    // Idle with tready high for n cycles; the output must stay empty
    task automatic quiet(input string nm, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 8'h00, 0, 1);
            if (outs() !== pk(0, 0, 2'b00, 8'h00, 0)) bad++;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    // Byte(s) already accepted; expect k-1 empty cycles then the timeout beat
    task automatic wait_tmo(input string nm, input int t, input logic [1:0] mu, input logic [7:0] md);
        for (int k = 1; k < t; k++) begin
            cyc(0, 8'h00, 0, 1);
            chk($sformatf("%s idle %0d", nm, k), outs(), pk(0, 0, 2'b00, 8'h00, 0));
        end
        cyc(0, 8'h00, 0, 1);
        chk({nm, " flush beat"}, outs(), pk(1, 1, mu, md, 1));
        cyc(0, 8'h00, 0, 1);
        chk({nm, " after flush"}, outs(), pk(0, 0, 2'b00, 8'h00, 0));
    endtask

    initial begin
        int badr, bado;
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tuser = 1'b0; m_axis_tready = 1'b1;
        timeout_config = 24'd0; delim_en = 1'b0; delim = 8'h00;

        // Delimiter framing: 41 42 0A closes, 43 stays held
        vt[0]  = mk(1, 8'h41, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);
        vt[1]  = mk(1, 8'h42, 0, 1,  1, 1, 0, 2'b00, 8'h41, 0);
        vt[2]  = mk(1, 8'h0A, 0, 1,  1, 1, 0, 2'b00, 8'h42, 0);
        vt[3]  = mk(1, 8'h43, 0, 1,  0, 1, 1, 2'b00, 8'h0A, 0);
        vt[4]  = mk(1, 8'h43, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);
        vt[5]  = mk(0, 8'h00, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);
        // MAX_LEN=4 framing: 01..04 closes, 05 out on 06 accept, 06 held
        vt[6]  = mk(1, 8'h01, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);
        vt[7]  = mk(1, 8'h02, 0, 1,  1, 1, 0, 2'b00, 8'h01, 0);
        vt[8]  = mk(1, 8'h03, 0, 1,  1, 1, 0, 2'b00, 8'h02, 0);
        vt[9]  = mk(1, 8'h04, 0, 1,  1, 1, 0, 2'b00, 8'h03, 0);
        vt[10] = mk(1, 8'h05, 0, 1,  0, 1, 1, 2'b00, 8'h04, 0);
        vt[11] = mk(1, 8'h05, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);
        vt[12] = mk(1, 8'h06, 0, 1,  1, 1, 0, 2'b00, 8'h05, 0);
        vt[13] = mk(0, 8'h00, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);
        vt[14] = mk(0, 8'h00, 0, 1,  1, 0, 0, 2'b00, 8'h00, 0);

        do_reset("init");

        delim_en = 1'b1; delim = 8'h0A; timeout_config = 24'd0;
        for (int i = 0; i <= 5; i++) run_vec(i);
        quiet("delim held byte stays", 100);

        do_reset("rst2");
        delim_en = 1'b0;
        for (int i = 6; i <= 14; i++) run_vec(i);
        quiet("maxlen held byte stays", 20);

        // Timeout close, T=16; config change after first accept must be ignored
        do_reset("rst3");
        timeout_config = 24'd16;
        cyc(1, 8'h11, 0, 1);
        chk("tmo acc 11", outs(), pk(0, 0, 2'b00, 8'h00, 0));
        timeout_config = 24'd0;
        cyc(1, 8'h22, 0, 1);
        chk("tmo out 11", outs(), pk(1, 0, 2'b00, 8'h11, 0));
        cyc(1, 8'h33, 0, 1);
        chk("tmo out 22", outs(), pk(1, 0, 2'b00, 8'h22, 0));
        wait_tmo("tmo16", 16, 2'b00, 8'h33);

        // Backpressure with error, T=8
        do_reset("rst4");
        timeout_config = 24'd8;
        drv(1, 8'hA0, 0, 0); #1;
        chk("bp srdy A0", 32'(s_axis_tready), 32'd1);
        tk();
        chk("bp acc A0", outs(), pk(0, 0, 2'b00, 8'h00, 0));
        drv(1, 8'hA1, 1, 0); #1;
        chk("bp srdy A1", 32'(s_axis_tready), 32'd1);
        tk();
        chk("bp out A0 stalled", outs(), pk(1, 0, 2'b00, 8'hA0, 0));
        badr = 0; bado = 0;
        for (int i = 0; i < 48; i++) begin
            drv(1, 8'hA2, 0, 0); #1;
            if (s_axis_tready !== 1'b0) badr++;
            tk();
            if (outs() !== pk(1, 0, 2'b00, 8'hA0, 0)) bado++;
        end
        chk("bp stall srdy low", 32'(badr), 32'd0);
        chk("bp stall out held", 32'(bado), 32'd0);
        drv(0, 8'h00, 0, 1); #1;
        chk("bp release A0 beat", outs(), pk(1, 0, 2'b00, 8'hA0, 0));
        tk();
        chk("bp A1 last err", outs(), pk(1, 1, 2'b11, 8'hA1, 1));
        cyc(0, 8'h00, 0, 1);
        chk("bp drained", outs(), pk(0, 0, 2'b00, 8'h00, 0));

        // Error on a non-last beat accumulates into the last beat's bit1
        cyc(1, 8'hC0, 1, 1);
        chk("acc C0", outs(), pk(0, 0, 2'b00, 8'h00, 0));
        cyc(1, 8'hC1, 0, 1);
        chk("out C0 err", outs(), pk(1, 0, 2'b01, 8'hC0, 0));
        wait_tmo("errpkt", 8, 2'b10, 8'hC1);
        // Next clean packet must not inherit the error
        cyc(1, 8'hD0, 0, 1);
        chk("acc D0", outs(), pk(0, 0, 2'b00, 8'h00, 0));
        wait_tmo("clean", 8, 2'b00, 8'hD0);

        // Race: next byte accepted on the threshold edge wins over timeout
        cyc(1, 8'hE0, 0, 1);
        chk("race acc E0", outs(), pk(0, 0, 2'b00, 8'h00, 0));
        for (int k = 1; k < 8; k++) cyc(0, 8'h00, 0, 1);
        chk("race pre", outs(), pk(0, 0, 2'b00, 8'h00, 0));
        cyc(1, 8'hE1, 0, 1);
        chk("race E0 no flush", outs(), pk(1, 0, 2'b00, 8'hE0, 0));
        wait_tmo("race E1", 8, 2'b00, 8'hE1);

        // Reset mid-packet discards output and held bytes without a flush
        cyc(1, 8'hF0, 0, 0);
        cyc(1, 8'hF1, 0, 0);
        chk("mid pkt out F0", outs(), pk(1, 0, 2'b00, 8'hF0, 0));
        do_reset("rst5");
        quiet("post reset no flush", 20);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
